// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshake-driven multi-cycle ALU with iterative shift-add multiply
//
// Ports:
//    clk         system clock, rising edge
//    reset       asynchronous active-low reset
//    req_valid   request present
//    req_ready   unit can accept a request (IDLE only)
//    a, b        operands, sampled only at acceptance
//    ALUControl  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B, 1000 MUL
//    rsp_valid   response valid (DONE)
//    rsp_ready   consumer accepts the response
//    result      registered result
//    zero        registered, 1 iff result == 0
//    err         registered, 1 iff the request used an illegal code
//    busy        unit is not IDLE
module alu_seq_unit #(
   parameter int N     = 64,
   parameter int CNT_W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ALUControl,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t         r_state;
   state_t         w_next;

   logic [N-1:0]   r_result;
   logic           r_zero;
   logic           r_err;
   logic [N-1:0]   r_acc;
   logic [N-1:0]   r_mcand;
   logic [N-1:0]   r_mplier;
   logic [CNT_W-1:0] r_cnt;

   logic [N-1:0]   w_alu_res;
   logic           w_illegal;
   logic           w_accept;
   logic           w_is_mul;
   logic           w_last;
   logic [N-1:0]   w_mul_next;

   // Single-cycle ALU; illegal codes leave the result at zero.
   always_comb begin
      w_alu_res = '0;
      w_illegal = 1'b0;
      case (ALUControl)
         OP_AND:  w_alu_res = a & b;
         OP_OR:   w_alu_res = a | b;
         OP_ADD:  w_alu_res = a + b;
         OP_SUB:  w_alu_res = a + ~b + N'(1);
         OP_PASS: w_alu_res = b;
         OP_MUL:  w_alu_res = '0;
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_accept   = req_valid && (r_state == S_IDLE);
   assign w_is_mul   = (ALUControl == OP_MUL);
   assign w_last     = (r_cnt == LAST_CNT);
   // Accumulator after this iteration's conditional add; on the last
   // iteration this is the final product.
   assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_is_mul ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         S_DONE: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: result/flags and the multiply iteration registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_acc    <= '0;
                     r_mcand  <= a;
                     r_mplier <= b;
                     r_cnt    <= '0;
                  end else begin
                     r_result <= w_alu_res;
                     r_zero   <= (w_alu_res == '0);
                     r_err    <= w_illegal;
                  end
               end
            end
            S_MUL: begin
               // Fixed N iterations; no early exit when the multiplier empties.
               r_acc    <= w_mul_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result <= w_mul_next;
                  r_zero   <= (w_mul_next == '0);
                  r_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign zero   = r_zero;
   assign err    = r_err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit
module tb_alu_seq_unit;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [3:0]  ALUControl;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] result;
   logic        zero;
   logic        err;
   logic        busy;

   int n_checks;
   int n_fail;

   // {err, zero, result}
   logic [65:0] sb_q[$];

   alu_seq_unit #(.N(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .result     (result),
      .zero       (zero),
      .err        (err),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] model(input logic [3:0] code, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r;
      logic        e;
      r = '0;
      e = 1'b0;
      case (code)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_ADD:  r = x + y;
         OP_SUB:  r = x - y;
         OP_PASS: r = y;
         OP_MUL:  r = x * y;
         default: e = 1'b1;
      endcase
      return {e, (r == 64'd0), r};
   endfunction

   task automatic push_exp(input logic [63:0] r, input logic z, input logic e);
      sb_q.push_back({e, z, r});
   endtask

   task automatic pop_check(input string tag);
      logic [65:0] ex;
      check_val({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         ex = sb_q.pop_front();
         check_val({tag, "_result"}, result, ex[63:0]);
         check_val({tag, "_zero"}, 64'(zero), 64'(ex[64]));
         check_val({tag, "_err"}, 64'(err), 64'(ex[65]));
      end
   endtask

   // Called at posedge+1 with the unit IDLE. Checks latency in edges after
   // the acceptance edge (0 = rsp_valid straight after acceptance).
   task automatic run_op(input string tag, input logic [3:0] code,
                         input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] er, input logic ez, input logic ee,
                         input int exp_lat);
      int lat;
      bit bad;
      req_valid  = 1'b1;
      ALUControl = code;
      a          = ia;
      b          = ib;
      rsp_ready  = 1'b1;
      push_exp(er, ez, ee);
      @(posedge clk); #1;
      // Operands are scrambled after acceptance; they must not matter.
      req_valid  = 1'b0;
      a          = ~ia;
      b          = ~ib;
      ALUControl = OP_AND;
      lat = 0;
      bad = 1'b0;
      while (!rsp_valid && lat < 200) begin
         if (req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      if (exp_lat > 0) check_val({tag, "_busy_hold"}, 64'(bad), 64'd0);
      pop_check(tag);
      @(posedge clk); #1;
      check_val({tag, "_idle"}, 64'({busy, rsp_valid, req_ready}), 64'b001);
   endtask

   initial begin
      logic [3:0]  codes[6];
      logic [65:0] m;
      logic [63:0] ra;
      logic [63:0] rb;

      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b0;
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      a          = '0;
      b          = '0;
      ALUControl = OP_AND;

      #3;
      check_val("rst_result", result, 64'd0);
      check_val("rst_flags", 64'({rsp_valid, busy, req_ready, zero, err}), 64'b00100);
      #19 reset = 1'b1;
      @(posedge clk); #1;

      // ADD
      run_op("add", OP_ADD, 64'd93846573825364758, 64'd27313240968594,
             64'd93873887066333352, 1'b0, 1'b0, 0);
      // SUB to zero, then SUB wrap
      run_op("sub_zero", OP_SUB, 64'd27586970463758451, 64'd27586970463758451,
             64'd0, 1'b1, 1'b0, 0);
      run_op("sub_wrap", OP_SUB, 64'd9223372036854775809, 64'd2,
             64'd9223372036854775807, 1'b0, 1'b0, 0);
      // MUL
      run_op("mul_3x5", OP_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 64);
      run_op("mul_ffx2", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64);

      // Backpressure: OR of zeros held while a new AND waits.
      req_valid  = 1'b1;
      ALUControl = OP_OR;
      a          = 64'd0;
      b          = 64'd0;
      rsp_ready  = 1'b0;
      push_exp(64'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      pop_check("bp_or");
      ALUControl = OP_AND;
      a          = 64'hF0F0_1234_5678_FFFF;
      b          = 64'hFF00_FF00_00FF_0F0F;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_val($sformatf("bp_hold_res%0d", i), result, 64'd0);
         check_val($sformatf("bp_hold_flags%0d", i),
                   64'({rsp_valid, req_ready, zero, err}), 64'b1010);
      end
      m = model(OP_AND, a, b);
      sb_q.push_back(m);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check_val("bp_handshake", 64'({busy, rsp_valid, req_ready}), 64'b001);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("bp_and_valid", 64'(rsp_valid), 64'd1);
      pop_check("bp_and");
      @(posedge clk); #1;
      check_val("bp_idle", 64'({busy, rsp_valid, req_ready}), 64'b001);

      // Reset during MUL iteration 30 discards the operation.
      req_valid  = 1'b1;
      ALUControl = OP_MUL;
      a          = 64'd12345;
      b          = 64'd678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (29) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check_val("rst_mid_flags", 64'({rsp_valid, busy}), 64'b00);
      check_val("rst_mid_result", result, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_mid_hold", 64'({rsp_valid, busy, req_ready}), 64'b001);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      run_op("and_after_rst", OP_AND, 64'd93846573825364758, 64'd27313240968594,
             64'd9715484885266, 1'b0, 1'b0, 0);

      // Illegal code, then a legal op clears err.
      run_op("illegal", 4'b0011, 64'd77, 64'd99, 64'd0, 1'b1, 1'b1, 0);
      run_op("after_illegal", OP_PASS, 64'd1, 64'hDEAD_BEEF_0000_0001,
             64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 0);

      // Random ops against the reference model.
      codes = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS, OP_MUL};
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         m  = model(codes[i], ra, rb);
         run_op($sformatf("rand%0d", i), codes[i], ra, rb, m[63:0], m[64], m[65],
                (codes[i] == OP_MUL) ? 64 : 0);
      end

      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Handshake-driven, multi-cycle ALU responder for the processor datapath.
- Accepts one operation per request and returns a registered result with a zero flag.
- Single-cycle ops use the combinational ALU control encoding. MUL is a fixed-latency iterative shift-add.
- Serves as the back-end for request/response drivers and checkers, and as the base for the future multi-cycle datapath.

Parameters:
N, 64, operand/result width in bits.
CNT_W, $clog2(N), width of the MUL iteration counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (combinational: high only in IDLE).
a  input  N  operand A, sampled only at acceptance.
b  input  N  operand B, sampled only at acceptance.
ALUControl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B, 1000 MUL (low N bits); all other codes illegal.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer accepts response.
result  output  N  registered result.
zero  output  1  registered; 1 iff result == 0.
err  output  1  registered; 1 iff the request used an illegal code.
busy  output  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any state, including mid-MUL):
  - state=IDLE; rsp_valid=0; result=0; zero=0; err=0.
  - Accumulator, multiplicand, multiplier and counter cleared.
  - An in-flight operation is discarded and produces no response.
- States: IDLE, MUL, DONE.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - Acceptance occurs at a rising edge with req_valid=1.
  - Logic, arithmetic or PASS B op: result/zero/err registered at the acceptance edge E; state goes to DONE. rsp_valid is high from edge E (latency 1 cycle).
  - Illegal code: result=0, zero=1, err=1; state goes to DONE at edge E.
  - MUL: at E load acc=0, mcand=a, mplier=b, cnt=0; state goes to MUL.
- MUL:
  - req_ready=0.
  - Each edge: if mplier[0], acc += mcand (mod 2^N); then mcand <<= 1, mplier >>= 1, cnt++.
  - Exactly N iterations, on edges E+1..E+N. No early termination.
  - At edge E+N: result=acc+final term, zero computed, err=0; state goes to DONE.
  - rsp_valid first high after edge E+N.
- DONE:
  - rsp_valid=1; result, zero and err held stable.
  - On an edge with rsp_ready=1: state goes to IDLE, rsp_valid=0, and result, zero and err retain their values.
  - req_ready=0 in DONE, so there is no accept-while-responding overlap. The earliest next acceptance is the edge after response handshake.
- Arithmetic: all ops modulo 2^N, no overflow or carry flag. SUB is a + ~b + 1. MUL keeps the low N bits of the unsigned/two's-complement product (identical for low half).
- req_valid while req_ready=0 is ignored; the initiator holds the request.
- Changes on a, b or ALUControl after acceptance have no effect.
- rsp_ready while rsp_valid=0 is ignored.
- busy=1 in MUL and DONE.

Test Plan:
1. ADD:
   - Stimulus: a=93846573825364758, b=27313240968594, code 0010, rsp_ready=1.
   - Response: rsp_valid high the cycle after acceptance; result=93873887066333352, zero=0, err=0. IDLE reached one cycle later.
2. SUB and zero:
   - Stimulus: a=b=27586970463758451, code 0110.
   - Response: result=0, zero=1. Then SUB a=9223372036854775809, b=2 gives result=9223372036854775807 (wrap, no flag).
3. MUL:
   - Stimulus: 3×5, then a=64'hFFFF_FFFF_FFFF_FFFF × b=2.
   - Response: rsp_valid first high exactly N=64 edges after acceptance; results 15 and 64'hFFFF_FFFF_FFFF_FFFE. req_ready=0 and busy=1 throughout.
4. Backpressure:
   - Stimulus: after an OR request (a=0, b=0), hold rsp_ready=0 for 5 cycles while driving req_valid=1 with a new AND.
   - Response: result=0, zero=1 stable; AND not accepted. Raise rsp_ready and the AND is accepted on the edge after the handshake.
5. Reset mid-operation:
   - Stimulus: assert reset=0 during MUL iteration 30.
   - Response: rsp_valid=0, busy=0, result=0 immediately (asynchronous). After release, an AND with a=93846573825364758, b=27313240968594 returns 9715484885266.
6. Illegal code:
   - Stimulus: ALUControl=0011.
   - Response: result=0, zero=1, err=1 with 1-cycle latency. The next legal request returns err=0.
